// File: rtl/uart_pkg.sv
// Shared state encoding and framing constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_FLAG,
    WAIT_DONE,
    RETIRE
  } txState_e;

  localparam int SIZE_DEFAULT = 32;

  // Overhead cycles beyond the data bits: first frame vs. each retransmission.
  localparam int FRAME_OVERHEAD = 4;
  localparam int RETRY_OVERHEAD = 3;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after lastGrant_i, with wrap.
module rr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int IW = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IW-1:0]          lastGrant_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IW-1:0]          grantIdx_o,
  output logic                   grantValid_o
);

  logic [IW-1:0] probe;
  logic          found;

  // Scan offsets 1..N so the previous winner is examined last.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    found      = 1'b0;
    probe      = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      probe = IW'((int'(lastGrant_i) + k) % NUM_CLIENTS);
      if (!found && req_i[probe]) begin
        found          = 1'b1;
        grant_o[probe] = 1'b1;
        grantIdx_o     = probe;
      end
    end
  end

  assign grantValid_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among several clients: round-robin grant, launch, NACK-capped retry, done timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int SIZE         = SIZE_DEFAULT,
  parameter int FRAME_LEN    = SIZE + FRAME_OVERHEAD,
  parameter int RETRY_LEN    = SIZE + RETRY_OVERHEAD,
  parameter int MAX_RETRY    = 3,
  parameter int DONE_TIMEOUT = 8
) (
  input  logic                            CLK_Baudin,
  input  logic                            RstTx,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS*SIZE-1:0]     data_in,
  output logic [NUM_CLIENTS-1:0]          ack,
  output logic [NUM_CLIENTS-1:0]          err,
  output logic [SIZE-1:0]                 tx_data,
  output logic                            tx_new_data,
  input  logic                            tx_done,
  input  logic                            rx_flag_in,
  output logic                            tx_flag_out,
  output logic                            busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]  cur_client
);

  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(maxInt(maxInt(FRAME_LEN, RETRY_LEN), DONE_TIMEOUT) + 1);

  txState_e        state_q, state_d;
  logic [SIZE-1:0] txData_q, txData_d;
  logic [IW-1:0]   curClient_q, curClient_d;
  logic [IW-1:0]   lastGrant_q, lastGrant_d;
  logic [RW-1:0]   retryCnt_q, retryCnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   limit_q, limit_d;
  logic            fail_q, fail_d;

  logic [NUM_CLIENTS-1:0] grantOneHot;
  logic [IW-1:0]          grantIdx;
  logic                   grantValid;
  logic [SIZE-1:0]        grantWord;
  logic                   forceAccept;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IW          (IW)
  ) uArb (
    .req_i        (req),
    .lastGrant_i  (lastGrant_q),
    .grant_o      (grantOneHot),
    .grantIdx_o   (grantIdx),
    .grantValid_o (grantValid)
  );

  always_comb begin
    grantWord = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grantOneHot[i]) grantWord = data_in[i*SIZE +: SIZE];
    end
  end

  // Once the retry budget is spent, the NACK is hidden so the transmitter finishes with its stop bit.
  assign forceAccept = (state_q == WAIT_FLAG) && (retryCnt_q == RW'(MAX_RETRY));
  assign tx_flag_out = rx_flag_in & ~forceAccept;

  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      state_q     <= IDLE;
      txData_q    <= '0;
      curClient_q <= '0;
      lastGrant_q <= IW'(NUM_CLIENTS - 1);
      retryCnt_q  <= '0;
      timer_q     <= '0;
      limit_q     <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      txData_q    <= txData_d;
      curClient_q <= curClient_d;
      lastGrant_q <= lastGrant_d;
      retryCnt_q  <= retryCnt_d;
      timer_q     <= timer_d;
      limit_q     <= limit_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    txData_d    = txData_q;
    curClient_d = curClient_q;
    lastGrant_d = lastGrant_q;
    retryCnt_d  = retryCnt_q;
    timer_d     = timer_q;
    limit_d     = limit_q;
    fail_d      = fail_q;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          txData_d    = grantWord;
          curClient_d = grantIdx;
          retryCnt_d  = '0;
          fail_d      = 1'b0;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        limit_d = TW'(FRAME_LEN);
        state_d = WAIT_FLAG;
      end
      WAIT_FLAG: begin
        if (timer_q == limit_q - 1'b1) begin
          timer_d = '0;
          if (!rx_flag_in) begin
            state_d = WAIT_DONE;
          end else if (!forceAccept) begin
            retryCnt_d = retryCnt_q + 1'b1;
            limit_d    = TW'(RETRY_LEN);
          end else begin
            fail_d  = 1'b1;
            state_d = WAIT_DONE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = RETIRE;
        end else if (timer_q == TW'(DONE_TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = RETIRE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RETIRE: begin
        lastGrant_d = curClient_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    err = '0;
    if (state_q == RETIRE) begin
      if (fail_q) err[curClient_q] = 1'b1;
      else        ack[curClient_q] = 1'b1;
    end
  end

  assign tx_new_data = (state_q == LAUNCH);
  assign busy        = (state_q != IDLE);
  assign tx_data     = txData_q;
  assign cur_client  = curClient_q;

endmodule
